// File: rtl/image_uart_loader_if.sv
// Bundle of the serial input and the framebuffer write-port side of the UART image loader.
// master = the loader itself, slave = whatever drives rx and consumes the RAM writes.
interface image_uart_loader_if #(
  parameter int ADDR_BITS = 16
);
  logic                 rx;
  logic                 wr_en;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [7:0]           wr_data;
  logic                 busy;
  logic                 frame_done;
  logic                 crc_err;
  logic                 frame_err;

  modport master (
    input  rx,
    output wr_en, wr_addr, wr_data, busy, frame_done, crc_err, frame_err
  );

  modport slave (
    output rx,
    input  wr_en, wr_addr, wr_data, busy, frame_done, crc_err, frame_err
  );
endinterface

// File: rtl/image_uart_loader.sv
// UART (8N1) receiver feeding a frame loader that writes SYNC-prefixed, XOR-checked
// images into the 8-bit pixel RAM scanned out by the VGA block.
module image_uart_loader #(
  parameter int         CLK_HZ    = 100_000_000,
  parameter int         BAUD      = 115_200,
  parameter int         ADDR_BITS = 16,
  parameter logic [7:0] SYNC_BYTE = 8'hA5
) (
  input logic          clk,
  input logic          clr,
  image_uart_loader_if.master bus
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = (CLKS_PER_BIT / 2 > 0) ? CLKS_PER_BIT / 2 : 1;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic [1:0] {L_SYNC, L_LOAD, L_CHECK} ld_state_t;

  // Two-flop synchronizer; idles high so reset cannot fake a start bit.
  logic r_rx_m, r_rx_s;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_rx_m <= 1'b1;
      r_rx_s <= 1'b1;
    end else begin
      r_rx_m <= bus.rx;
      r_rx_s <= r_rx_m;
    end
  end

  rx_state_t        r_rstate, w_rstate_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]       r_bit, w_bit_nxt;
  logic [7:0]       r_shift, w_shift_nxt;
  logic             r_byte_vld, w_byte_vld_nxt;
  logic             r_frame_err, w_frame_err_nxt;
  logic             w_half_hit, w_bit_hit;

  assign w_half_hit = (r_cnt == CNT_W'(HALF_BIT - 1));
  assign w_bit_hit  = (r_cnt == CNT_W'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk) begin
    if (clr) begin
      r_rstate    <= R_IDLE;
      r_cnt       <= '0;
      r_bit       <= '0;
      r_byte_vld  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_rstate    <= w_rstate_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bit       <= w_bit_nxt;
      r_byte_vld  <= w_byte_vld_nxt;
      r_frame_err <= w_frame_err_nxt;
    end
    r_shift <= w_shift_nxt;
  end

  always_comb begin
    w_rstate_nxt    = r_rstate;
    w_cnt_nxt       = r_cnt;
    w_bit_nxt       = r_bit;
    w_shift_nxt     = r_shift;
    w_byte_vld_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    case (r_rstate)
      R_IDLE: begin
        if (!r_rx_s) begin
          w_rstate_nxt = R_START;
          w_cnt_nxt    = '0;
          w_bit_nxt    = '0;
        end
      end
      R_START: begin
        // Mid-start-bit recheck rejects short low glitches on the line.
        if (w_half_hit) begin
          w_cnt_nxt    = '0;
          w_rstate_nxt = r_rx_s ? R_IDLE : R_DATA;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      R_DATA: begin
        if (w_bit_hit) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[7:1]};
          w_bit_nxt   = r_bit + 3'd1;
          if (r_bit == 3'd7) w_rstate_nxt = R_STOP;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      R_STOP: begin
        // Back to idle at mid-stop so a following start edge is caught on time.
        if (w_bit_hit) begin
          w_cnt_nxt       = '0;
          w_rstate_nxt    = R_IDLE;
          w_byte_vld_nxt  = r_rx_s;
          w_frame_err_nxt = ~r_rx_s;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  ld_state_t            r_lstate, w_lstate_nxt;
  logic [ADDR_BITS-1:0] r_idx, w_idx_nxt;
  logic [ADDR_BITS-1:0] r_wr_addr, w_wr_addr_nxt;
  logic [7:0]           r_wr_data, w_wr_data_nxt;
  logic [7:0]           r_csum, w_csum_nxt;
  logic                 r_wr_en, w_wr_en_nxt;
  logic                 r_busy, w_busy_nxt;
  logic                 r_done, w_done_nxt;
  logic                 r_crc, w_crc_nxt;

  always_ff @(posedge clk) begin
    if (clr) begin
      r_lstate  <= L_SYNC;
      r_idx     <= '0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_csum    <= '0;
      r_wr_en   <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_crc     <= 1'b0;
    end else begin
      r_lstate  <= w_lstate_nxt;
      r_idx     <= w_idx_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_csum    <= w_csum_nxt;
      r_wr_en   <= w_wr_en_nxt;
      r_busy    <= w_busy_nxt;
      r_done    <= w_done_nxt;
      r_crc     <= w_crc_nxt;
    end
  end

  always_comb begin
    w_lstate_nxt  = r_lstate;
    w_idx_nxt     = r_idx;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    w_csum_nxt    = r_csum;
    w_wr_en_nxt   = 1'b0;
    w_busy_nxt    = r_busy;
    w_done_nxt    = 1'b0;
    w_crc_nxt     = 1'b0;
    case (r_lstate)
      L_SYNC: begin
        if (r_byte_vld && r_shift == SYNC_BYTE) begin
          w_lstate_nxt  = L_LOAD;
          w_busy_nxt    = 1'b1;
          w_wr_addr_nxt = '0;
          w_idx_nxt     = '0;
          w_csum_nxt    = '0;
        end
      end
      L_LOAD: begin
        if (r_frame_err) begin
          w_lstate_nxt = L_SYNC;
          w_busy_nxt   = 1'b0;
        end else if (r_byte_vld) begin
          w_wr_en_nxt   = 1'b1;
          w_wr_data_nxt = r_shift;
          w_wr_addr_nxt = r_idx;
          w_csum_nxt    = r_csum ^ r_shift;
          w_idx_nxt     = r_idx + ADDR_BITS'(1);
          if (r_idx == '1) w_lstate_nxt = L_CHECK;
        end
      end
      L_CHECK: begin
        if (r_frame_err) begin
          w_lstate_nxt = L_SYNC;
          w_busy_nxt   = 1'b0;
        end else if (r_byte_vld) begin
          w_lstate_nxt = L_SYNC;
          w_busy_nxt   = 1'b0;
          w_done_nxt   = (r_shift == r_csum);
          w_crc_nxt    = (r_shift != r_csum);
        end
      end
      default: w_lstate_nxt = L_SYNC;
    endcase
  end

  // Status pulses are masked while clr is held so none can appear during reset.
  assign bus.wr_en      = r_wr_en;
  assign bus.wr_addr    = r_wr_addr;
  assign bus.wr_data    = r_wr_data;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_done & ~clr;
  assign bus.crc_err    = r_crc & ~clr;
  assign bus.frame_err  = r_frame_err & ~clr;

endmodule
